// File: rtl/out_channel_reader_pkg.sv
// Shared types and helpers for the zero machine out channel reader.
package zero_channel_pkg;

  localparam int WordWidth = 12;

  typedef logic [WordWidth-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } chan_state_t;

  function automatic int unsigned wrap_inc(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/out_channel_reader_if.sv
// Producer/consumer bundle of the out channel reader.
interface out_channel_reader_if #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut = 8,
  parameter int CountWidth = 12
);

  logic                            out_we;
  logic [MemoryElementWidth-1:0]   out_data;
  logic                            out_stall;
  logic                            program_done;
  logic                            rd_valid;
  logic                            rd_ready;
  logic [MemoryElementWidth-1:0]   rd_data;
  logic [$clog2(NOut+1)-1:0]       count;
  logic [CountWidth-1:0]           overflow_count;
  logic                            late_write;
  logic                            drained;

  modport master (
    output out_we,
    output out_data,
    output program_done,
    output rd_ready,
    input  out_stall,
    input  rd_valid,
    input  rd_data,
    input  count,
    input  overflow_count,
    input  late_write,
    input  drained
  );

  modport slave (
    input  out_we,
    input  out_data,
    input  program_done,
    input  rd_ready,
    output out_stall,
    output rd_valid,
    output rd_data,
    output count,
    output overflow_count,
    output late_write,
    output drained
  );

endinterface

// File: rtl/out_channel_reader_ring.sv
// NOut-deep word ring with explicitly wrapping pointers.
module channel_ring
  import zero_channel_pkg::*;
#(
  parameter int MemoryElementWidth = 12,
  parameter int NOut = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [MemoryElementWidth-1:0] wdata,
  output logic [$clog2(NOut+1)-1:0]     count,
  output logic [$clog2(NOut+1)-1:0]     count_d,
  output logic [MemoryElementWidth-1:0] head_d,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = $clog2(NOut);
  localparam int CW = $clog2(NOut + 1);

  logic [MemoryElementWidth-1:0] mem [NOut];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_d;

  assign full  = (count == CW'(NOut));
  assign empty = (count == '0);

  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    count_d  = count;
    if (push) wr_ptr_d = PW'(wrap_inc(32'(wr_ptr), NOut));
    if (pop)  rd_ptr_d = PW'(wrap_inc(32'(rd_ptr), NOut));
    unique case (1'b1)
      push && !pop: count_d = count + 1'b1;
      pop && !push: count_d = count - 1'b1;
      default: ;
    endcase
    // the slot being written this cycle may already be the next head
    head_d = (push && wr_ptr == rd_ptr_d) ? wdata : mem[rd_ptr_d];
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      count  <= count_d;
    end
  end

endmodule

// File: rtl/out_channel_reader.sv
// Out channel consumer: ring, delivery stream, completion FSM.
// OUT_CHANNEL_OVERWRITE_EN: a full ring overwrites its oldest word.
module out_channel_reader
  import zero_channel_pkg::*;
#(
  parameter int MemoryElementWidth = 12,
  parameter int NOut = 8,
  parameter int CountWidth = 12
) (
  input logic              clock,
  input logic              reset,
  out_channel_reader_if.slave bus
);

  localparam int CW = $clog2(NOut + 1);

  chan_state_t state;
  chan_state_t state_d;

  logic [CW-1:0]                 count;
  logic [CW-1:0]                 count_d;
  logic [MemoryElementWidth-1:0] head_d;
  logic [MemoryElementWidth-1:0] rd_data_q;
  logic [CountWidth-1:0]         ovf_q;
  logic full;
  logic empty;
  logic stall;
  logic push;
  logic pop;
  logic rd_fire;
  logic lose;
  logic drop;
  logic rd_valid_q;
  logic late_q;
  logic drained;

  assign rd_fire = rd_valid_q && bus.rd_ready;

`ifdef OUT_CHANNEL_OVERWRITE_EN
  assign stall = 1'b0;
  assign lose  = push && full && !rd_fire;
  assign drop  = 1'b0;
`else
  assign stall = full;
  assign lose  = 1'b0;
  assign drop  = bus.out_we && full && (state != DONE);
`endif

  assign push = bus.out_we && !stall && (state != DONE);
  // an overwrite retires the oldest word along with the push
  assign pop  = rd_fire || lose;

  channel_ring #(
    .MemoryElementWidth(MemoryElementWidth),
    .NOut(NOut)
  ) u_ring (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wdata  (bus.out_data),
    .count  (count),
    .count_d(count_d),
    .head_d (head_d),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (bus.program_done) state_d = push ? FLUSH : DONE;
        else if (push)        state_d = STREAM;
      end
      STREAM: if (bus.program_done) state_d = FLUSH;
      FLUSH:  if (empty && !push)   state_d = DONE;
      DONE:   ;
      default: ;
    endcase
  end

  always_comb begin
    drained = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= '0;
      late_q     <= 1'b0;
    end else begin
      rd_valid_q <= (count_d != '0);
      if (count_d != '0) rd_data_q <= head_d;
      if ((drop || lose) && ovf_q != '1) ovf_q <= ovf_q + 1'b1;
      if (bus.out_we && state == DONE) late_q <= 1'b1;
    end
  end

  assign bus.out_stall      = stall;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.count          = count;
  assign bus.overflow_count = ovf_q;
  assign bus.late_write     = late_q;
  assign bus.drained        = drained;

endmodule

// File: tb/tb_out_channel_reader.sv
// Randomized bench for out_channel_reader against a queue model.
module tb_out_channel_reader;
  import zero_channel_pkg::*;

  localparam int NOUT = 8;
  localparam int CWID = 12;
  localparam int unsigned OVF_MAX = (1 << CWID) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  out_channel_reader_if #(
    .MemoryElementWidth(12), .NOut(NOUT), .CountWidth(CWID)
  ) bus ();

  out_channel_reader #(
    .MemoryElementWidth(12), .NOut(NOUT), .CountWidth(CWID)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int ntests = 0;
  int nfail = 0;

  word_t       mq[$];
  int unsigned movf = 0;
  bit mlate = 0, mstart = 0, mflush = 0, mdone = 0;
  bit m_rd, m_acc, m_empty, m_full;

  task automatic chk(string nm, int unsigned act, int unsigned exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: ordered queue of undelivered words plus completion flags
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      movf = 0; mlate = 0; mstart = 0; mflush = 0; mdone = 0;
    end else if (mdone) begin
      if (bus.out_we) mlate = 1;
    end else begin
      m_rd    = (mq.size() != 0) && bus.rd_ready;
      m_empty = (mq.size() == 0);
      m_full  = (mq.size() == NOUT);
      m_acc   = 0;
      if (bus.out_we) begin
`ifdef OUT_CHANNEL_OVERWRITE_EN
        m_acc = 1;
        if (m_full && !m_rd) begin
          void'(mq.pop_front());
          if (movf != OVF_MAX) movf++;
        end
`else
        if (m_full) begin
          if (movf != OVF_MAX) movf++;
        end else m_acc = 1;
`endif
      end
      if (m_rd) void'(mq.pop_front());
      if (m_acc) mq.push_back(bus.out_data);
      if (!mstart && !mflush && bus.program_done && !m_acc) mdone = 1;
      else if (mflush && m_empty && !m_acc) mdone = 1;
      if (bus.program_done) mflush = 1;
      if (m_acc) mstart = 1;
    end
  end

  always @(negedge clk) begin
    chk("rd_valid", 32'(bus.rd_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("rd_data", 32'(bus.rd_data), 32'(mq[0]));
    chk("count", 32'(bus.count), 32'(mq.size()));
`ifdef OUT_CHANNEL_OVERWRITE_EN
    chk("out_stall", 32'(bus.out_stall), 0);
`else
    chk("out_stall", 32'(bus.out_stall), 32'(mq.size() == NOUT));
`endif
    chk("overflow", 32'(bus.overflow_count), movf);
    chk("late", 32'(bus.late_write), 32'(mlate));
    chk("drained", 32'(bus.drained), 32'(mdone));
  end

  task automatic cyc(bit we, int unsigned d, bit rdy, bit pd);
    bus.out_we = we;
    bus.out_data = 12'(d);
    bus.rd_ready = rdy;
    bus.program_done = pd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  word_t wq[$];
  word_t got[$];

  initial begin
    do_reset();
    chk("rst_valid", 32'(bus.rd_valid), 0);
    chk("rst_data", 32'(bus.rd_data), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_ovf", 32'(bus.overflow_count), 0);
    chk("rst_stall", 32'(bus.out_stall), 0);
    chk("rst_drained", 32'(bus.drained), 0);

    // in-order delivery, one cycle after each write
    cyc(1, 111, 1, 0);
    chk("t1_d0", 32'(bus.rd_data), 111);
    cyc(1, 333, 1, 0);
    chk("t1_d1", 32'(bus.rd_data), 333);
    chk("t1_c1", 32'(bus.count), 1);
    cyc(0, 0, 1, 0);
    chk("t1_c0", 32'(bus.count), 0);

    // fill to full, one extra write
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, i, 0, 0);
    chk("t2_count", 32'(bus.count), 8);
`ifdef OUT_CHANNEL_OVERWRITE_EN
    chk("t2_stall", 32'(bus.out_stall), 0);
`else
    chk("t2_stall", 32'(bus.out_stall), 1);
`endif
    cyc(1, 9, 0, 0);
    chk("t2_ovf", 32'(bus.overflow_count), 1);
    for (int i = 0; i < 8; i++) begin
`ifdef OUT_CHANNEL_OVERWRITE_EN
      chk("t2_rd", 32'(bus.rd_data), 32'(i + 2));
`else
      chk("t2_rd", 32'(bus.rd_data), 32'(i + 1));
`endif
      cyc(0, 0, 1, 0);
    end
    chk("t2_empty", 32'(bus.count), 0);

    // full ring, write together with an accepted read
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, i, 0, 0);
    cyc(1, 50, 1, 0);
`ifdef OUT_CHANNEL_OVERWRITE_EN
    chk("t3_count", 32'(bus.count), 8);
    chk("t3_ovf", 32'(bus.overflow_count), 0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_rd", 32'(bus.rd_data), (i == 7) ? 50 : 32'(i + 2));
      cyc(0, 0, 1, 0);
    end
`else
    chk("t3_count", 32'(bus.count), 7);
    chk("t3_ovf", 32'(bus.overflow_count), 1);
    for (int i = 0; i < 7; i++) begin
      chk("t3_rd", 32'(bus.rd_data), 32'(i + 2));
      cyc(0, 0, 1, 0);
    end
`endif

    // completion with queued words, then a late write
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 20 + i, 0, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("t4_c0", 32'(bus.count), 0);
    cyc(0, 0, 1, 0);
    chk("t4_drained", 32'(bus.drained), 1);
    cyc(1, 7, 1, 0);
    chk("t4_late", 32'(bus.late_write), 1);
    chk("t4_count", 32'(bus.count), 0);
    chk("t4_valid", 32'(bus.rd_valid), 0);

    // program_done while idle finishes at once
    do_reset();
    cyc(0, 0, 0, 1);
    chk("idle_done", 32'(bus.drained), 1);

    // reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 40 + i, 0, 0);
    do_reset();
    chk("t5_valid", 32'(bus.rd_valid), 0);
    chk("t5_count", 32'(bus.count), 0);
    chk("t5_ovf", 32'(bus.overflow_count), 0);
    cyc(1, 77, 0, 0);
    chk("t5_restart", 32'(bus.rd_data), 77);
    chk("t5_drained", 32'(bus.drained), 0);

    // random ready toggling: order kept, no duplicates
    do_reset();
    wq.delete();
    got.delete();
    for (int i = 0; i < 4; i++) begin
      wq.push_back(12'($urandom_range(0, 4095)));
      cyc(1, wq[i], 0, 0);
    end
    for (int i = 0; i < 24; i++) begin
      bit r;
      r = 1'($urandom_range(0, 1));
      if (r && bus.rd_valid) got.push_back(bus.rd_data);
      cyc(0, 0, r, 0);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.rd_valid) got.push_back(bus.rd_data);
      cyc(0, 0, 1, 0);
    end
    chk("t6_n", 32'(got.size()), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("t6_order", 32'(got[i]), 32'(wq[i]));

    // long random run through completion
    do_reset();
    for (int i = 0; i < 250; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom_range(0, 4095),
          1'($urandom_range(0, 2) == 0), 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 4095),
          1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0);
    chk("rnd_drained", 32'(bus.drained), 1);
    cyc(1, 5, 1, 0);
    for (int i = 0; i < 10; i++)
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 4095), 1, 0);
    chk("rnd_late", 32'(bus.late_write), 1);

    // random run with sporadic resets
    for (int i = 0; i < 200; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      cyc(1'($urandom_range(0, 2) != 0), $urandom_range(0, 4095),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 60) == 0));
    end
    rst = 1'b0;
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
